// File: rtl/ctl_pipe_pkg.sv
// Shared constants for the control pipeline: instruction fields,
// bundle layout, bubble value and halt FSM states.
package ctl_pipe_pkg;

    localparam logic [1:0] CLS_LD  = 2'b00;
    localparam logic [1:0] CLS_ST  = 2'b01;
    localparam logic [1:0] CLS_BR  = 2'b10;
    localparam logic [1:0] CLS_ALU = 2'b11;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_CMP = 4'b0101;
    localparam logic [3:0] OP_LIM = 4'b0110;
    localparam logic [3:0] OP_R7  = 4'b0111;
    localparam logic [3:0] OP_SH0 = 4'b1000;
    localparam logic [3:0] OP_SH3 = 4'b1011;
    localparam logic [3:0] OP_IN  = 4'b1100;
    localparam logic [3:0] OP_OUT = 4'b1101;
    localparam logic [3:0] OP_RE  = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [2:0] BR_LI   = 3'b000;
    localparam logic [2:0] BR_ADDI = 3'b001;
    localparam logic [2:0] BR_B    = 3'b100;
    localparam logic [2:0] BR_BCC  = 3'b111;
    localparam logic [2:0] BR_NONE = 3'b111;

    localparam int O_VALID   = 0;
    localparam int O_MEM_RD  = 1;
    localparam int O_MEM_WR  = 2;
    localparam int O_REG_WR  = 3;
    localparam int O_ALU_S1  = 4;
    localparam int O_ALU_S2  = 5;
    localparam int O_M2R     = 6;
    localparam int O_OUT_EN  = 7;
    localparam int O_IN_EN   = 8;
    localparam int O_AOS     = 9;
    localparam int O_HALT    = 10;
    localparam int O_AS_BC   = 11;
    localparam int O_ALU_OP  = 12;
    localparam int O_BRANCH  = 16;
    localparam int O_REG_DST = 19;

    // Bundle width excluding reg_dst; reg_dst sits on top.
    localparam int CTL_FIXED_W = 19;
    localparam int CTL_W = CTL_FIXED_W + 3;

    localparam logic [CTL_W-1:0] BUBBLE = {3'b000, BR_NONE, 16'h0000};

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_e;

endpackage

// File: rtl/ctl_decode.sv
// Combinational decoder: 16-bit instruction to control bundle.
// The valid bit is always set; the pipeline decides what is loaded.
module ctl_decode
    import ctl_pipe_pkg::*;
#(
    parameter int REG_AW = 3
) (
    input  logic [15:0]                   inst,
    output logic [CTL_FIXED_W+REG_AW-1:0] ctl
);

    logic [1:0] cls;
    logic [3:0] op;
    logic [2:0] br;
    logic       c_ld;
    logic       c_st;
    logic       c_br;
    logic       c_alu;
    logic       unused;

    assign unused = ^inst[3:0];

    always_comb begin
        cls   = inst[15:14];
        op    = inst[7:4];
        br    = inst[13:11];
        c_ld  = (cls == CLS_LD);
        c_st  = (cls == CLS_ST);
        c_br  = (cls == CLS_BR);
        c_alu = (cls == CLS_ALU);
        ctl   = '0;

        ctl[O_VALID]  = 1'b1;
        ctl[O_MEM_RD] = c_ld;
        ctl[O_MEM_WR] = c_st;
        ctl[O_REG_WR] = (c_alu && !(op == OP_CMP || op == OP_R7
                        || op == OP_OUT || op == OP_RE
                        || op == OP_HLT))
                        || c_ld
                        || (c_br && (br == BR_LI || br == BR_ADDI));
        ctl[O_ALU_S1] = c_br && (br != BR_LI);
        ctl[O_ALU_S2] = !(c_alu && op <= OP_LIM);
        ctl[O_M2R]    = c_ld || (c_alu && op == OP_IN);
        ctl[O_OUT_EN] = c_alu && (op == OP_OUT);
        ctl[O_IN_EN]  = c_alu && (op == OP_IN);
        ctl[O_AOS]    = c_alu && (op >= OP_SH0) && (op <= OP_SH3);
        ctl[O_HALT]   = c_alu && (op == OP_HLT);
        ctl[O_AS_BC]  = c_alu && !(op == OP_R7 || op == OP_IN
                        || op == OP_OUT || op == OP_RE
                        || op == OP_HLT);

        if (c_alu)
            ctl[O_ALU_OP +: 4] = op;
        else if (c_br && br == BR_LI)
            ctl[O_ALU_OP +: 4] = OP_LIM;
        else
            ctl[O_ALU_OP +: 4] = OP_ADD;

        if (c_br && br == BR_BCC)
            ctl[O_BRANCH +: 3] = inst[10:8];
        else if (c_br && br == BR_B)
            ctl[O_BRANCH +: 3] = 3'b100;
        else
            ctl[O_BRANCH +: 3] = BR_NONE;

        // Loads name their target in the br field.
        ctl[O_REG_DST +: REG_AW] = c_ld ? inst[11 +: REG_AW]
                                        : inst[8 +: REG_AW];
    end

endmodule

// File: rtl/ctl_pipe_stage.sv
// Control pipeline: decode, stall/flush/load-use handling and
// a halt-drain FSM over NUM_STAGES registered bundle stages.
module ctl_pipe_stage
    import ctl_pipe_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int REG_AW     = 3,
    parameter int HAZARD_EN  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] inst,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic        stall_in,
    input  logic        flush,
    output logic [NUM_STAGES*(CTL_FIXED_W+REG_AW)-1:0] ctl_stage,
    output logic        hazard_stall,
    output logic        halted
);

    localparam int CW   = CTL_FIXED_W + REG_AW;
    localparam int LAST = NUM_STAGES - 1;
    localparam logic [CW-1:0] BUB = {{REG_AW{1'b0}}, BR_NONE, 16'h0000};

    logic [CW-1:0]     ctl_q [NUM_STAGES];
    logic [CW-1:0]     ctl_d [NUM_STAGES];
    logic [CW-1:0]     dec;
    logic [REG_AW-1:0] rd0;
    state_e            state_q;
    state_e            state_d;
    logic              hazard;
    logic              ready;
    logic              accept;

    ctl_decode #(.REG_AW(REG_AW)) u_dec (
        .inst (inst),
        .ctl  (dec)
    );

    always_comb begin
        rd0    = ctl_q[0][O_REG_DST +: REG_AW];
        hazard = (HAZARD_EN != 0) && inst_valid
                 && ctl_q[0][O_VALID] && ctl_q[0][O_MEM_RD]
                 && (rd0 == inst[11 +: REG_AW]
                     || rd0 == inst[8 +: REG_AW]);
        ready  = (state_q == ST_RUN) && !stall_in && !hazard && !flush;
        accept = inst_valid && ready;

        for (int k = 0; k < NUM_STAGES; k++)
            ctl_d[k] = ctl_q[k];

        if (state_q == ST_HALTED) begin
            for (int k = 0; k < NUM_STAGES; k++)
                ctl_d[k] = BUB;
        end else if (stall_in) begin
            if (flush)
                ctl_d[0] = BUB;
        end else begin
            // A flush kills stage 0, so it must not advance into stage 1.
            for (int k = 1; k < NUM_STAGES; k++)
                ctl_d[k] = (k == 1 && flush) ? BUB : ctl_q[k-1];
            ctl_d[0] = accept ? dec : BUB;
        end

        state_d = state_q;
        if (state_q == ST_RUN && accept && dec[O_HALT])
            state_d = ST_DRAIN;
        if (state_d == ST_DRAIN) begin
            if (flush && ctl_q[0][O_VALID] && ctl_q[0][O_HALT])
                state_d = ST_RUN;
            else if (ctl_d[LAST][O_VALID] && ctl_d[LAST][O_HALT])
                state_d = ST_HALTED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_STAGES; k++)
                ctl_q[k] <= BUB;
            state_q <= ST_RUN;
        end else begin
            for (int k = 0; k < NUM_STAGES; k++)
                ctl_q[k] <= ctl_d[k];
            state_q <= state_d;
        end
    end

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_out
        assign ctl_stage[g*CW +: CW] = ctl_q[g];
    end

    assign inst_ready   = ready;
    assign hazard_stall = hazard && !rst;
    assign halted       = (state_q == ST_HALTED);

endmodule

// File: tb/tb_ctl_pipe_stage.sv
// Directed bench: expected bundles queued at issue, checked by a
// monitor at the last stage; side signals checked inline.
module tb_ctl_pipe_stage;

    localparam int CW = 22;
    localparam int NS = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   inst;
    logic          inst_valid;
    logic          inst_ready;
    logic          stall_in;
    logic          flush;
    logic [NS*CW-1:0] ctl_stage;
    logic          hazard_stall;
    logic          halted;

    logic [CW-1:0] expq [$];
    logic [CW-1:0] mon_e;
    logic          adv = 1'b1;
    int            nvec = 0;
    int            nbad = 0;

    ctl_pipe_stage #(.NUM_STAGES(NS), .REG_AW(3), .HAZARD_EN(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst         (inst),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .stall_in     (stall_in),
        .flush        (flush),
        .ctl_stage    (ctl_stage),
        .hazard_stall (hazard_stall),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    // flags = {as_bc,halt,aos,in,out,m2r,s2,s1,rw,mw,mr,valid}
    function automatic logic [CW-1:0] bnd(input logic [11:0] flags,
                                          input logic [3:0] aop,
                                          input logic [2:0] rd,
                                          input logic [2:0] br);
        return {rd, br, aop, flags};
    endfunction

    localparam logic [CW-1:0] B_BUB  = {3'b000, 3'b111, 4'h0, 12'h000};
    localparam logic [CW-1:0] B_C100 = {3'b001, 3'b111, 4'h0, 12'b1000_0000_1001};
    localparam logic [CW-1:0] B_C800 = {3'b000, 3'b111, 4'h0, 12'b1000_0000_1001};
    localparam logic [CW-1:0] B_LD   = {3'b001, 3'b111, 4'h0, 12'b0000_0110_1011};
    localparam logic [CW-1:0] B_BCC  = {3'b001, 3'b001, 4'h0, 12'b0000_0011_0001};
    localparam logic [CW-1:0] B_HLT  = {3'b000, 3'b111, 4'hF, 12'b0100_0010_0001};

    task automatic chk(input string nm, input logic [NS*CW-1:0] act,
                       input logic [NS*CW-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) adv <= !stall_in;

    always @(negedge clk) begin
        if (!rst && adv && ctl_stage[(NS-1)*CW]) begin
            if (expq.size() == 0) begin
                nvec++;
                nbad++;
                $display("FAIL mon_unexpected: got %h, want none",
                         ctl_stage[(NS-1)*CW +: CW]);
            end else begin
                mon_e = expq.pop_front();
                chk("mon_last", ctl_stage[(NS-1)*CW +: CW], mon_e);
            end
        end
    end

    initial begin
        rst = 1'b1; inst = 16'h0; inst_valid = 1'b0;
        stall_in = 1'b0; flush = 1'b0;
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_stages", ctl_stage, {B_BUB, B_BUB, B_BUB});
        chk("rst_halted", halted, 0);
        chk("rst_hazard", hazard_stall, 0);
        chk("rst_ready", inst_ready, 1);

        // Basic latency with ADD r1, r0.
        inst = 16'hC100; inst_valid = 1'b1; expq.push_back(B_C100);
        step();
        inst_valid = 1'b0;
        #1 chk("add_s0", ctl_stage[0 +: CW], B_C100);
        step(); step();
        chk("add_s2", ctl_stage[2*CW +: CW], B_C100);
        step();

        // Load-use bubble.
        inst = 16'h0A05; inst_valid = 1'b1; expq.push_back(B_LD);
        #1 chk("ld_ready", inst_ready, 1);
        step();
        inst = 16'hC800;
        #1 chk("hz_on", hazard_stall, 1);
        chk("hz_ready", inst_ready, 0);
        step();
        chk("hz_bubble", ctl_stage[0 +: CW], B_BUB);
        chk("hz_off", hazard_stall, 0);
        chk("hz_ready2", inst_ready, 1);
        chk("ld_s1", ctl_stage[CW +: CW], B_LD);
        expq.push_back(B_C800);
        step();
        inst_valid = 1'b0;
        #1 chk("use_s0", ctl_stage[0 +: CW], B_C800);
        step(); step(); step();

        // Conditional branch then flush.
        inst = 16'hB900; inst_valid = 1'b1;
        step();
        inst = 16'hC100; flush = 1'b1;
        #1 chk("bcc_s0", ctl_stage[0 +: CW], B_BCC);
        chk("flush_ready", inst_ready, 0);
        step();
        flush = 1'b0; inst_valid = 1'b0;
        #1 chk("flush_s0", ctl_stage[0 +: CW], B_BUB);
        step(); step();

        // Fill the pipe, then stall three cycles.
        inst = 16'hC100; inst_valid = 1'b1; expq.push_back(B_C100);
        step();
        inst = 16'hC800; expq.push_back(B_C800);
        step();
        inst = 16'h0A05; expq.push_back(B_LD);
        step();
        inst = 16'hC200; stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hold", ctl_stage, {B_C100, B_C800, B_LD});
            chk("stall_ready", inst_ready, 0);
        end
        stall_in = 1'b0; inst_valid = 1'b0;
        step();
        chk("rel_adv1", ctl_stage, {B_C800, B_LD, B_BUB});
        step();
        chk("rel_adv2", ctl_stage, {B_LD, B_BUB, B_BUB});
        step(); step();

        // Halt drain to HALTED.
        inst = 16'hC0F0; inst_valid = 1'b1; expq.push_back(B_HLT);
        #1 chk("hlt_ready", inst_ready, 1);
        step();
        inst = 16'hC100;
        #1 chk("drain_ready", inst_ready, 0);
        chk("drain_h0", halted, 0);
        step();
        chk("drain_h1", halted, 0);
        step();
        chk("halted_on", halted, 1);
        chk("hlt_s2", ctl_stage[2*CW +: CW], B_HLT);
        step();
        chk("halted_bub", ctl_stage, {B_BUB, B_BUB, B_BUB});
        chk("halted_ready", inst_ready, 0);
        chk("halted_hold", halted, 1);
        inst_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        #1 chk("unhalt_h", halted, 0);
        chk("unhalt_ready", inst_ready, 1);

        // Flush kills halt in stage 0: back to RUN.
        inst = 16'hC0F0; inst_valid = 1'b1;
        step();
        inst_valid = 1'b0; flush = 1'b1;
        #1 chk("hk_ready", inst_ready, 0);
        step();
        flush = 1'b0;
        #1 chk("hk_s0", ctl_stage[0 +: CW], B_BUB);
        chk("hk_run", inst_ready, 1);
        step(); step(); step();
        chk("hk_halted", halted, 0);

        // Reset during DRAIN.
        inst = 16'hC0F0; inst_valid = 1'b1;
        step();
        inst_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1 chk("rd_stages", ctl_stage, {B_BUB, B_BUB, B_BUB});
        chk("rd_halted", halted, 0);
        chk("rd_ready", inst_ready, 1);
        step(); step(); step(); step();
        chk("queue_empty", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
